nv_nvdla_cvif_read_eg_dma4_pack: RTL and testbench

Read-egress packer for CVIF client port 4 (rubik). It accepts 256-bit read-return beats from the CVIF egress demux and assembles them into 514-bit atom-pair responses (512 data + 2-bit mask). It drives the dma4 valid/ready/pd interface into the client's p6 output skid/pipe stage. It contains one half-word accumulator, one output register and a response counter.

---
 rtl/nv_nvdla_cvif_read_eg_dma4_pack_if.sv | 21 ++
 rtl/nv_nvdla_cvif_read_eg_dma4_pack.sv | 87 ++++++++
 tb/tb_nv_nvdla_cvif_read_eg_dma4_pack.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/nv_nvdla_cvif_read_eg_dma4_pack_if.sv
// Beat-side and dma4-side handshake bundle for the CVIF port-4 read-egress packer.
// The slave modport is the packer's view of the bus.
interface nv_nvdla_cvif_read_eg_dma4_pack_if;
  logic         eg2dma4_beat_vld;
  logic         eg2dma4_beat_rdy;
  logic [255:0] eg2dma4_beat_data;
  logic         eg2dma4_beat_last;
  logic         dma4_vld;
  logic         dma4_rdy;
  logic [513:0] dma4_pd;

  modport slave (
    input  eg2dma4_beat_vld, eg2dma4_beat_data, eg2dma4_beat_last, dma4_rdy,
    output eg2dma4_beat_rdy, dma4_vld, dma4_pd
  );

  modport master (
    output eg2dma4_beat_vld, eg2dma4_beat_data, eg2dma4_beat_last, dma4_rdy,
    input  eg2dma4_beat_rdy, dma4_vld, dma4_pd
  );
endinterface

// File: rtl/nv_nvdla_cvif_read_eg_dma4_pack.sv
// Packs 256-bit CVIF read-return beats into 514-bit {mask, data} atom pairs
// for the rubik dma4 client, and counts delivered responses.
module nv_nvdla_cvif_read_eg_dma4_pack #(
  parameter int CNT_W = 16
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  nv_nvdla_cvif_read_eg_dma4_pack_if.slave bus,
  output logic [CNT_W-1:0]     dma4_rsp_cnt,
  input  logic                 dma4_cnt_clr
);
  localparam int BEAT_W = 256;

  typedef enum logic {LOW_EMPTY = 1'b0, LOW_HELD = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                vld_q, vld_d;
  logic [2*BEAT_W+1:0] pd_q, pd_d;
  logic [BEAT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic out_free;
  logic beat_rdy;
  logic accept;
  logic load;
  logic out_hs;

  assign out_free = !vld_q || bus.dma4_rdy;
  assign out_hs   = vld_q && bus.dma4_rdy;

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    pd_d     = pd_q;
    acc_d    = acc_q;
    beat_rdy = out_free;
    load     = 1'b0;
    // A first half only touches the accumulator, so it never waits on the output.
    if (state_q == LOW_EMPTY && !bus.eg2dma4_beat_last) beat_rdy = 1'b1;
    accept = bus.eg2dma4_beat_vld && beat_rdy;

    if (out_hs) vld_d = 1'b0;

    if (accept) begin
      if (state_q == LOW_HELD) begin
        load    = 1'b1;
        pd_d    = {2'b11, bus.eg2dma4_beat_data, acc_q};
        state_d = LOW_EMPTY;
      end else if (bus.eg2dma4_beat_last) begin
        load = 1'b1;
        pd_d = {2'b01, {BEAT_W{1'b0}}, bus.eg2dma4_beat_data};
      end else begin
        acc_d   = bus.eg2dma4_beat_data;
        state_d = LOW_HELD;
      end
    end

    if (load) vld_d = 1'b1;

    cnt_d = cnt_q;
    if (dma4_cnt_clr) cnt_d = '0;
    else if (out_hs) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= LOW_EMPTY;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers carry no reset; their contents are qualified by state/valid.
  always_ff @(posedge nvdla_core_clk) begin
    pd_q  <= pd_d;
    acc_q <= acc_d;
  end

  assign bus.eg2dma4_beat_rdy = beat_rdy;
  assign bus.dma4_vld         = vld_q;
  assign bus.dma4_pd          = pd_q;
  assign dma4_rsp_cnt         = cnt_q;
endmodule

// File: tb/tb_nv_nvdla_cvif_read_eg_dma4_pack.sv
// Scoreboard bench for the dma4 packer: stimulus pushes expected pd words,
// a negedge monitor pops and compares on every dma4 handshake.
module tb_nv_nvdla_cvif_read_eg_dma4_pack;
  logic        clk;
  logic        rst;
  logic [15:0] rsp_cnt;
  logic        cnt_clr;

  nv_nvdla_cvif_read_eg_dma4_pack_if bus ();

  nv_nvdla_cvif_read_eg_dma4_pack #(.CNT_W(16)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus),
    .dma4_rsp_cnt   (rsp_cnt),
    .dma4_cnt_clr   (cnt_clr)
  );

  int checks = 0;
  int errors = 0;
  logic [513:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [513:0] act, input logic [513:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a handshake happens at the next posedge iff vld&&rdy now.
  always @(negedge clk) begin
    if (!rst && bus.dma4_vld && bus.dma4_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got %h want none", bus.dma4_pd);
      end else begin
        logic [513:0] e;
        e = exp_q.pop_front();
        if (bus.dma4_pd !== e) begin
          errors++;
          $display("FAIL sb_pd got %h want %h", bus.dma4_pd, e);
        end
      end
    end
  end

  function automatic logic [255:0] pat(input logic [31:0] s);
    return {8{s}};
  endfunction

  // Present one beat until accepted; returns number of cycles it was presented.
  task automatic send(input logic [255:0] d, input logic last, output int tries);
    logic took;
    bus.eg2dma4_beat_vld  = 1'b1;
    bus.eg2dma4_beat_data = d;
    bus.eg2dma4_beat_last = last;
    tries = 0;
    took = 1'b0;
    while (!took && tries < 50) begin
      @(negedge clk);
      took = bus.eg2dma4_beat_rdy;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!took) begin
      errors++;
      checks++;
      $display("FAIL send_timeout got tries=%0d want accept", tries);
    end
    bus.eg2dma4_beat_vld = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [255:0] a, b, c, d, e, f, g, x;
    logic [513:0] pend;

    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.eg2dma4_beat_vld  = 1'b0;
    bus.eg2dma4_beat_data = '0;
    bus.eg2dma4_beat_last = 1'b0;
    bus.dma4_rdy = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_vld", {513'b0, bus.dma4_vld}, 514'd0);
    check("rst_rdy", {513'b0, bus.eg2dma4_beat_rdy}, 514'd1);
    check("rst_cnt", {498'b0, rsp_cnt}, 514'd0);

    // Two-beat pair A,B
    a = pat(32'hA0A0_0001);
    b = pat(32'hB0B0_0002);
    exp_q.push_back({2'b11, b, a});
    send(a, 1'b0, t);
    send(b, 1'b1, t);
    check("pair_vld", {513'b0, bus.dma4_vld}, 514'd1);
    check("pair_pd", bus.dma4_pd, {2'b11, b, a});
    tick();
    check("pair_cnt", {498'b0, rsp_cnt}, 514'd1);
    check("pair_drained", {513'b0, bus.dma4_vld}, 514'd0);

    // Single beat C
    c = pat(32'hC0C0_0003);
    exp_q.push_back({2'b01, 256'h0, c});
    send(c, 1'b1, t);
    check("single_pd", bus.dma4_pd, {2'b01, 256'h0, c});
    tick();

    // Backpressure: one pair pending, then D accepted, E stalls
    bus.dma4_rdy = 1'b0;
    x = pat(32'h5555_0004);
    pend = {2'b01, 256'h0, x};
    exp_q.push_back(pend);
    send(x, 1'b1, t);
    d = pat(32'hD0D0_0005);
    e = pat(32'hE0E0_0006);
    send(d, 1'b0, t);
    check("bp_d_tries", 514'(t), 514'd1);
    exp_q.push_back({2'b11, e, d});
    bus.eg2dma4_beat_vld  = 1'b1;
    bus.eg2dma4_beat_data = e;
    bus.eg2dma4_beat_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_e_stall", {513'b0, bus.eg2dma4_beat_rdy}, 514'd0);
      check("bp_pd_hold", bus.dma4_pd, pend);
      tick();
    end
    bus.dma4_rdy = 1'b1;
    @(negedge clk);
    check("bp_e_release", {513'b0, bus.eg2dma4_beat_rdy}, 514'd1);
    tick();
    bus.eg2dma4_beat_vld = 1'b0;
    check("bp_new_vld", {513'b0, bus.dma4_vld}, 514'd1);
    check("bp_new_pd", bus.dma4_pd, {2'b11, e, d});
    tick();

    // Stream of 8 beats, last on every second one
    for (int i = 0; i < 8; i++) begin
      logic [255:0] s, lo;
      s = pat(32'h1000_0000 + i);
      if (i % 2 == 1) begin
        lo = pat(32'h1000_0000 + i - 1);
        exp_q.push_back({2'b11, s, lo});
      end
      send(s, (i % 2 == 1), t);
      check("stream_nobubble", 514'(t), 514'd1);
      check("stream_vld", {513'b0, bus.dma4_vld}, {513'b0, (i % 2 == 1)});
    end
    tick();
    check("stream_cnt", {498'b0, rsp_cnt}, 514'd8);

    // Reset while LOW_HELD with an undelivered pair
    bus.dma4_rdy = 1'b0;
    exp_q.push_back({2'b01, 256'h0, pat(32'h7777_0007)});
    send(pat(32'h7777_0007), 1'b1, t);
    send(pat(32'h8888_0008), 1'b0, t);
    rst = 1'b1;
    bus.eg2dma4_beat_vld  = 1'b1;
    bus.eg2dma4_beat_data = pat(32'h9999_0009);
    bus.eg2dma4_beat_last = 1'b1;
    tick();
    exp_q.delete();
    rst = 1'b0;
    bus.eg2dma4_beat_vld = 1'b0;
    check("rst2_vld", {513'b0, bus.dma4_vld}, 514'd0);
    check("rst2_rdy", {513'b0, bus.eg2dma4_beat_rdy}, 514'd1);
    check("rst2_cnt", {498'b0, rsp_cnt}, 514'd0);
    bus.dma4_rdy = 1'b1;
    f = pat(32'hF0F0_000F);
    exp_q.push_back({2'b01, 256'h0, f});
    send(f, 1'b1, t);
    check("rst2_f_pd", bus.dma4_pd, {2'b01, 256'h0, f});
    tick();
    check("rst2_f_cnt", {498'b0, rsp_cnt}, 514'd1);

    // Counter wrap and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt", {498'b0, rsp_cnt}, 514'd0);
    for (int i = 0; i < 65535; i++) begin
      g = pat(i);
      exp_q.push_back({2'b01, 256'h0, g});
      send(g, 1'b1, t);
    end
    tick();
    check("cnt_ffff", {498'b0, rsp_cnt}, {498'b0, 16'hFFFF});
    g = pat(32'h2222_0022);
    exp_q.push_back({2'b01, 256'h0, g});
    send(g, 1'b1, t);
    tick();
    check("cnt_wrap", {498'b0, rsp_cnt}, 514'd0);
    g = pat(32'h3333_0033);
    exp_q.push_back({2'b01, 256'h0, g});
    send(g, 1'b1, t);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_hs", {498'b0, rsp_cnt}, 514'd0);
    tick();
    check("sb_empty", 514'(exp_q.size()), 514'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
